// File: rtl/led_ser_pkg.sv
// ---------------------------------------------------------------------------
// led_ser_pkg : shared types and defaults for the LED frame serializer. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package led_ser_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_CLK_DIV = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // Lone requester wins; on a tie the one not served last time wins.
  function automatic logic arb_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_ser_shreg.sv
// ---------------------------------------------------------------------------
// led_ser_shreg : WIDTH-bit load/shift-right register, LSB is the serial tap. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_ser_shreg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             q_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // Zeros shift in, so the tap idles low once a frame has fully drained.
  always_comb begin
    shreg_d = shreg_q;
    if (load_i)
      shreg_d = d_i;
    else if (shift_en_i)
      shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst)
      shreg_q <= '0;
    else
      shreg_q <= shreg_d;
  end

  assign q_o = shreg_q[0];

endmodule

`default_nettype wire

// File: rtl/led_ser_sched.sv
// ---------------------------------------------------------------------------
// led_ser_sched : two-requester arbiter driving a serial LED shift-register link. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_ser_sched
  import led_ser_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack0,
  output logic             ack1,
  output logic             ser_out,
  output logic             sclk,
  output logic             latch,
  output logic             busy,
  output logic             done,
  output logic             last_grant
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic [BIT_W-1:0] bit_q;
  logic             sclk_q;
  logic             latch_q;
  logic             done_q;
  logic             busy_q;
  logic             ack0_q;
  logic             ack1_q;
  logic             last_q;

  logic             win_d;
  logic             grant_d;
  logic             div_end_d;
  logic             load_d;
  logic             shift_d;
  logic [WIDTH-1:0] frame_d;

  // Grants are decided on the GAP edge as well, so a held request is acked
  // in the very first IDLE cycle; the ack cycle itself stays in IDLE.
  always_comb begin
    win_d     = arb_pick(req0, req1, last_q);
    div_end_d = (div_q == DIV_LAST);
    grant_d   = (req0 || req1) &&
                (((state_q == ST_IDLE) && !(ack0_q || ack1_q)) || (state_q == ST_GAP));
    load_d    = (state_q == ST_IDLE) && (ack0_q || ack1_q);
    shift_d   = (state_q == ST_SHIFT) && div_end_d && sclk_q;
    frame_d   = last_q ? data1 : data0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      ack0_q <= grant_d && !win_d;
      ack1_q <= grant_d && win_d;
      if (grant_d)
        last_q <= win_d;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ack0_q || ack1_q) begin
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
            div_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (div_end_d) begin
            div_q <= '0;
            if (sclk_q) begin
              sclk_q <= 1'b0;
              bit_q  <= bit_q + BIT_W'(1);
              if (bit_q == BIT_LAST) begin
                state_q <= ST_LATCH;
                latch_q <= 1'b1;
              end
            end else begin
              sclk_q <= 1'b1;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        ST_LATCH: begin
          if (div_end_d) begin
            div_q   <= '0;
            latch_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_GAP;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  led_ser_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_d),
    .shift_en_i (shift_d),
    .d_i        (frame_d),
    .q_o        (ser_out)
  );

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign sclk       = sclk_q;
  assign latch      = latch_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign last_grant = last_q;

endmodule

`default_nettype wire

// File: tb/tb_led_ser_sched.sv
// ---------------------------------------------------------------------------
// tb_led_ser_sched : two instances (CLK_DIV=1 and 3) checked against a frame scoreboard. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_led_ser_sched;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_w  [2];
  logic         req1_w  [2];
  logic [W-1:0] data0_w [2];
  logic [W-1:0] data1_w [2];
  logic         ack0_w  [2];
  logic         ack1_w  [2];
  logic         ser_w   [2];
  logic         sclk_w  [2];
  logic         latch_w [2];
  logic         busy_w  [2];
  logic         done_w  [2];
  logic         lg_w    [2];

  always #5 clk = ~clk;

  led_ser_sched #(.WIDTH(W), .CLK_DIV(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0(req0_w[0]), .data0(data0_w[0]), .req1(req1_w[0]), .data1(data1_w[0]),
    .ack0(ack0_w[0]), .ack1(ack1_w[0]), .ser_out(ser_w[0]), .sclk(sclk_w[0]),
    .latch(latch_w[0]), .busy(busy_w[0]), .done(done_w[0]), .last_grant(lg_w[0])
  );

  led_ser_sched #(.WIDTH(W), .CLK_DIV(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0(req0_w[1]), .data0(data0_w[1]), .req1(req1_w[1]), .data1(data1_w[1]),
    .ack0(ack0_w[1]), .ack1(ack1_w[1]), .ser_out(ser_w[1]), .sclk(sclk_w[1]),
    .latch(latch_w[1]), .busy(busy_w[1]), .done(done_w[1]), .last_grant(lg_w[1])
  );

  typedef struct packed {
    logic         k;
    logic         who;
    logic [W-1:0] data;
  } exp_t;

  typedef struct {
    logic         r0;
    logic         r1;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         who;
  } vec_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int cd_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Per-instance frame monitor state
  logic         active    [2] = '{1'b0, 1'b0};
  logic         who_m     [2];
  logic         lg_m      [2];
  logic         prev_sclk [2] = '{1'b0, 1'b0};
  logic [W-1:0] bits      [2];
  int           t_ack     [2];
  int           nbits     [2];
  int           latch_cnt [2];
  int           run       [2];
  int           bad       [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        active[k] = 1'b0;
      end else if (ack0_w[k] || ack1_w[k]) begin
        chk("busy_in_ack_cycle", 32'(busy_w[k]), 32'd0);
        chk("single_ack", 32'(ack0_w[k] && ack1_w[k]), 32'd0);
        active[k]    = 1'b1;
        t_ack[k]     = cyc;
        who_m[k]     = ack1_w[k];
        lg_m[k]      = lg_w[k];
        bits[k]      = '0;
        nbits[k]     = 0;
        latch_cnt[k] = 0;
        run[k]       = 0;
        bad[k]       = 0;
      end else if (active[k]) begin
        if (sclk_w[k] != prev_sclk[k]) begin
          if (run[k] != cd_of(k)) bad[k]++;
          run[k] = 1;
          if (sclk_w[k]) begin
            if (nbits[k] < W) bits[k][4'(nbits[k])] = ser_w[k];
            nbits[k]++;
          end
        end else begin
          run[k]++;
        end
        if (latch_w[k]) begin
          latch_cnt[k]++;
          if (ser_w[k] || sclk_w[k]) bad[k]++;
        end
        if (!busy_w[k]) bad[k]++;
        if (done_w[k]) begin
          active[k] = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("frame_dut", 32'(k), 32'(e.k));
            chk("frame_grant", 32'(who_m[k]), 32'(e.who));
            chk("frame_last_grant", 32'(lg_m[k]), 32'(e.who));
            chk("frame_data", 32'(bits[k]), 32'(e.data));
            chk("frame_nbits", 32'(nbits[k]), 32'(W));
            chk("frame_len", 32'(cyc - t_ack[k] + 1), 32'(2 * cd_of(k) * W + cd_of(k) + 2));
            chk("frame_latch_cycles", 32'(latch_cnt[k]), 32'(cd_of(k)));
            chk("frame_shape_errs", 32'(bad[k]), 32'd0);
          end
        end
      end else if (done_w[k] || latch_w[k]) begin
        chk("stray_done_or_latch", {30'd0, done_w[k], latch_w[k]}, 32'd0);
      end
      prev_sclk[k] = sclk_w[k];
    end
  end

  task automatic wait_ack(input int k, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (ack0_w[k] || ack1_w[k]) ok = 1'b1;
    end
    if (!ok) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int k, output int nack);
    logic seen;
    seen = 1'b0;
    nack = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (ack0_w[k] || ack1_w[k]) nack++;
      if (done_w[k]) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int k, input int n, output int nack);
    nack = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ack0_w[k] || ack1_w[k]) nack++;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] out_vec(input int k);
    return {24'd0, ack0_w[k], ack1_w[k], ser_w[k], sclk_w[k],
            latch_w[k], busy_w[k], done_w[k], lg_w[k]};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    logic ok;
    int   nack;
    int   t_prev;
    int   rises;
    logic psclk;

    tbl[0] = '{r0: 1'b1, r1: 1'b0, d0: 16'hA5C3, d1: 16'h0000, who: 1'b0};
    tbl[1] = '{r0: 1'b0, r1: 1'b1, d0: 16'h0000, d1: 16'h1234, who: 1'b1};
    tbl[2] = '{r0: 1'b1, r1: 1'b1, d0: 16'h0F0F, d1: 16'hF0F0, who: 1'b0};
    tbl[3] = '{r0: 1'b1, r1: 1'b1, d0: 16'h8001, d1: 16'h7FFE, who: 1'b1};
    tbl[4] = '{r0: 1'b0, r1: 1'b1, d0: 16'h0000, d1: 16'h5555, who: 1'b1};
    tbl[5] = '{r0: 1'b1, r1: 1'b1, d0: 16'hAAAA, d1: 16'h0001, who: 1'b0};

    for (int k = 0; k < 2; k++) begin
      req0_w[k]  = 1'b0;
      req1_w[k]  = 1'b0;
      data0_w[k] = '0;
      data1_w[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) chk("reset_outputs", out_vec(k), 32'h01);
    rst = 1'b0;

    // Table of single frames, including ties resolved by last_grant
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{k: 1'b0, who: tbl[i].who, data: tbl[i].who ? tbl[i].d1 : tbl[i].d0});
      data0_w[0] = tbl[i].d0;
      data1_w[0] = tbl[i].d1;
      req0_w[0]  = tbl[i].r0;
      req1_w[0]  = tbl[i].r1;
      wait_ack(0, ok);
      chk("vec_ack_winner", {30'd0, ack1_w[0], ack0_w[0]}, tbl[i].who ? 32'd2 : 32'd1);
      req0_w[0] = 1'b0;
      req1_w[0] = 1'b0;
      wait_done(0, nack);
      chk("vec_no_extra_ack", 32'(nack), 32'd0);
    end

    // Both requests held: alternating grants, back to back with one idle cycle
    pulse_reset();
    data0_w[0] = 16'hFFFF;
    data1_w[0] = 16'h0000;
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{k: 1'b0, who: 1'(i % 2), data: (i % 2 == 1) ? 16'h0000 : 16'hFFFF});
    req0_w[0] = 1'b1;
    req1_w[0] = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(0, ok);
      chk("alt_order", 32'(ack1_w[0]), 32'(i % 2));
      if (i > 0) chk("b2b_gap", 32'(cyc - t_prev), 32'd1);
      if (i == 3) begin
        req0_w[0] = 1'b0;
        req1_w[0] = 1'b0;
      end
      wait_done(0, nack);
      t_prev = cyc;
    end
    idle_cycles(0, 3, nack);

    // req1 pulsed only while shifting is dropped, not queued
    exp_q.push_back('{k: 1'b0, who: 1'b0, data: 16'h3C3C});
    data0_w[0] = 16'h3C3C;
    req0_w[0]  = 1'b1;
    wait_ack(0, ok);
    req0_w[0] = 1'b0;
    idle_cycles(0, 10, nack);
    req1_w[0] = 1'b1;
    idle_cycles(0, 5, nack);
    chk("no_ack_during_shift", 32'(nack), 32'd0);
    req1_w[0] = 1'b0;
    wait_done(0, nack);
    chk("no_ack_before_done", 32'(nack), 32'd0);
    @(negedge clk);
    chk("busy_after_done", 32'(busy_w[0]), 32'd0);
    idle_cycles(0, 20, nack);
    chk("no_queued_req", 32'(nack), 32'd0);

    // Reset at bit 7 aborts the frame
    data0_w[0] = 16'hFFFF;
    req0_w[0]  = 1'b1;
    wait_ack(0, ok);
    req0_w[0] = 1'b0;
    rises = 0;
    psclk = 1'b0;
    for (int i = 0; i < 200 && rises < 8; i++) begin
      @(negedge clk);
      if (sclk_w[0] && !psclk) rises++;
      psclk = sclk_w[0];
    end
    chk("reached_bit7", 32'(rises), 32'd8);
    rst = 1'b1;
    @(negedge clk);
    chk("midframe_reset_outputs", out_vec(0), 32'h01);
    rst = 1'b0;
    idle_cycles(0, 60, nack);
    chk("no_resume_after_reset", 32'(nack), 32'd0);
    exp_q.push_back('{k: 1'b0, who: 1'b0, data: 16'h1357});
    data0_w[0] = 16'h1357;
    req0_w[0]  = 1'b1;
    wait_ack(0, ok);
    chk("grant_after_reset", 32'(ack0_w[0]), 32'd1);
    req0_w[0] = 1'b0;
    wait_done(0, nack);

    // CLK_DIV=3 instance: 3/3 sclk phases, 3-cycle latch, 101-cycle frame
    exp_q.push_back('{k: 1'b1, who: 1'b0, data: 16'hC0DE});
    data0_w[1] = 16'hC0DE;
    req0_w[1]  = 1'b1;
    wait_ack(1, ok);
    req0_w[1] = 1'b0;
    wait_done(1, nack);
    idle_cycles(1, 3, nack);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_ser_sched.md
LED_SER_SCHED -- requirements
Module: led_ser_sched

Interface
REQ-001 Parameter WIDTH, default 16: bits per LED frame, legal range 2..32.
REQ-002 Parameter CLK_DIV, default 4: clk cycles per serial half-bit, legal range 1..255.
REQ-003 clk  in  1: single clock, rising-edge.
REQ-004 rst  in  1: synchronous, active-high reset.
REQ-005 req0  in  1: requester 0 wants one frame sent (level).
REQ-006 data0  in  WIDTH: requester 0 frame, sampled on ack0.
REQ-007 req1  in  1: requester 1 wants one frame sent (level).
REQ-008 data1  in  WIDTH: requester 1 frame, sampled on ack1.
REQ-009 ack0 / ack1  out  1 each: one-cycle grant pulse; the frame is captured in that cycle.
REQ-010 ser_out  out  1: serial data, LSB first.
REQ-011 sclk  out  1: serial shift clock to the LED driver.
REQ-012 latch  out  1: storage-register strobe after the last bit.
REQ-013 busy  out  1: high in every state except IDLE.
REQ-014 done  out  1: one-cycle pulse at frame completion.
REQ-015 last_grant  out  1: index of the most recently granted requester.

Function
REQ-016 FSM states are IDLE, SHIFT, LATCH and GAP.
REQ-017 IDLE with req0|req1: assert ack of the winner for exactly one cycle, load the shift register from its data, set last_grant, enter SHIFT next cycle.
REQ-018 Arbitration: if only one req is high it wins; if both are high the winner is the requester not equal to last_grant.
REQ-019 Each bit occupies 2*CLK_DIV cycles: sclk low for CLK_DIV cycles with ser_out = shreg[0] stable, then sclk high for CLK_DIV cycles.
REQ-020 On the sclk high->low transition the register shifts right by one and the bit counter increments.
REQ-021 After bit WIDTH-1 completes its high phase: sclk=0, enter LATCH; latch=1 for CLK_DIV cycles, ser_out=0.
REQ-022 LATCH->GAP: done=1 for the single GAP cycle, latch=0, then IDLE.
REQ-023 Frame length from ack to done inclusive is 2*CLK_DIV*WIDTH + CLK_DIV + 2 cycles.
REQ-024 req is ignored outside IDLE; a req held through a frame is granted in the first IDLE cycle after GAP.
REQ-025 A req deasserted before ack sends no frame; no request is queued.
REQ-026 The divider counter is ceil(log2(CLK_DIV+1)) bits and the bit counter ceil(log2(WIDTH+1)) bits; neither counter wraps mid-frame.
REQ-027 No ack may be issued in any cycle where busy=1.

Reset
REQ-028 With rst=1 at a clk edge: state=IDLE, ack0=ack1=0, ser_out=0, sclk=0, latch=0, busy=0, done=0, last_grant=1 (so requester 0 wins the first tie), counters=0, shift register=0.
REQ-029 Reset mid-frame aborts the frame: no done, no latch, and no ack in the reset cycle; the frame is not resumed.

Structure
REQ-030 Package led_ser_pkg holds the state enum and the default WIDTH and CLK_DIV constants.
REQ-031 The single sub-module is led_ser_shreg: a WIDTH-bit load/shift register with load, shift_en and q outputs; the FSM, arbiter and divider live in led_ser_sched.

Verification
REQ-032 WIDTH=16, CLK_DIV=1; req0=1 with data0=16'hA5C3 -> ack0 one cycle later, ser_out bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on sclk rising edges, latch 1 cycle, done 35 cycles after ack0.
REQ-033 req0 and req1 held high after reset -> grants in the order ack0, ack1, ack0, ack1, with last_grant toggling each frame.
REQ-034 req1 pulsed during SHIFT only -> no ack1, and busy falls after done.
REQ-035 rst=1 at bit 7 of a frame -> next cycle all outputs are at reset values, no done, and a new req0 is then granted normally.
REQ-036 CLK_DIV=3 -> sclk has 3 low and 3 high cycles per bit, latch is high for 3 cycles, and the frame length is 101 cycles.
REQ-037 data0=16'hFFFF then data1=16'h0000 back to back -> 16 ones then 16 zeros, with exactly one GAP+IDLE cycle between frames.
